score_display: RTL and testbench

//  Drives the 4-digit multiplexed 7-segment display from game-manager status. Downstream of
//  the game manager: consumes level, round/answer counters, per-round result and game_end.

---
 rtl/game_pkg.sv | 99 +++++++++
 rtl/seg_glyph_rom.sv | 42 ++++
 rtl/score_display.sv | 213 +++++++++++++++++++++
 tb/tb_score_display.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Definitions shared by the display blocks of the game:
//   - disp_state_t : display FSM state encodings (IDLE/PLAY/FLASH/RESULT)
//   - glyph_t      : abstract glyph codes, turned into segments by seg_glyph_rom
//   - LVL_*        : one-hot level constants
//   - bcd_t / bcd_split   : tens/ones split of a 0..31 value
//   - digit_glyph         : decimal digit -> glyph code
//   - level_is_valid      : true only for the three one-hot level encodings
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FLASH  = 2'd2,
    ST_RESULT = 2'd3
  } disp_state_t;

  typedef enum logic [4:0] {
    CH_0     = 5'd0,
    CH_1     = 5'd1,
    CH_2     = 5'd2,
    CH_3     = 5'd3,
    CH_4     = 5'd4,
    CH_5     = 5'd5,
    CH_6     = 5'd6,
    CH_7     = 5'd7,
    CH_8     = 5'd8,
    CH_9     = 5'd9,
    CH_DASH  = 5'd10,
    CH_BLANK = 5'd11,
    CH_P     = 5'd12,
    CH_A     = 5'd13,
    CH_S     = 5'd14,
    CH_F     = 5'd15,
    CH_I     = 5'd16,
    CH_L     = 5'd17,
    CH_C     = 5'd18
  } glyph_t;

  localparam logic [2:0] LVL_1 = 3'b001;
  localparam logic [2:0] LVL_2 = 3'b010;
  localparam logic [2:0] LVL_3 = 3'b100;

  typedef struct packed {
    logic [1:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Inputs never exceed 31, so tens is at most 3 and a compare chain suffices.
  function automatic bcd_t bcd_split(input logic [4:0] v);
    bcd_t       r;
    logic [4:0] base;
    if (v >= 5'd30) begin
      r.tens = 2'd3;
      base   = 5'd30;
    end else if (v >= 5'd20) begin
      r.tens = 2'd2;
      base   = 5'd20;
    end else if (v >= 5'd10) begin
      r.tens = 2'd1;
      base   = 5'd10;
    end else begin
      r.tens = 2'd0;
      base   = 5'd0;
    end
    r.ones = 4'(v - base);
    return r;
  endfunction

  function automatic glyph_t digit_glyph(input logic [3:0] d);
    glyph_t g;
    case (d)
      4'd0:    g = CH_0;
      4'd1:    g = CH_1;
      4'd2:    g = CH_2;
      4'd3:    g = CH_3;
      4'd4:    g = CH_4;
      4'd5:    g = CH_5;
      4'd6:    g = CH_6;
      4'd7:    g = CH_7;
      4'd8:    g = CH_8;
      4'd9:    g = CH_9;
      default: g = CH_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic level_is_valid(input logic [2:0] lvl);
    logic ok;
    case (lvl)
      LVL_1, LVL_2, LVL_3: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// ---------------------------------------------------------------------------
// seg_glyph_rom
// Combinational lookup from glyph code to 7-segment pattern.
// Ports:
//   code    in  glyph_t  abstract glyph code
//   pattern out 7        {g,f,e,d,c,b,a}, active-high; unknown codes are blank
// ---------------------------------------------------------------------------
module seg_glyph_rom
  import game_pkg::*;
(
  input  glyph_t     code,
  output logic [6:0] pattern
);

  // Glyph code to segment pattern table
  always_comb begin
    pattern = 7'h00;
    case (code)
      CH_0:     pattern = 7'h3F;
      CH_1:     pattern = 7'h06;
      CH_2:     pattern = 7'h5B;
      CH_3:     pattern = 7'h4F;
      CH_4:     pattern = 7'h66;
      CH_5:     pattern = 7'h6D;
      CH_6:     pattern = 7'h7D;
      CH_7:     pattern = 7'h07;
      CH_8:     pattern = 7'h7F;
      CH_9:     pattern = 7'h6F;
      CH_DASH:  pattern = 7'h40;
      CH_BLANK: pattern = 7'h00;
      CH_P:     pattern = 7'h73;
      CH_A:     pattern = 7'h77;
      CH_S:     pattern = 7'h6D;
      CH_F:     pattern = 7'h71;
      CH_I:     pattern = 7'h30;
      CH_L:     pattern = 7'h38;
      CH_C:     pattern = 7'h58;  // lower-case c
      default:  pattern = 7'h00;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// ---------------------------------------------------------------------------
// score_display
// Drives a 4-digit multiplexed 7-segment display from game-manager status:
// "----" with no level, level + round number during play, PASS/FAIL for
// FLASH_CYCLES after each round, and "Sc" + answer count once the game ends.
// Optional feature macro: SCORE_BLINK_EN -- blinks the result screen with a
// half-period of BLINK_CYCLES (digit scanning continues while blanked).
// Ports:
//   clk          in  1  clock, posedge
//   rst          in  1  asynchronous reset, active-low
//   level        in  3  one-hot level (001/010/100), anything else = no level
//   round_count  in  5  completed rounds 0..31
//   answer_count in  4  correct rounds 0..15
//   round_done   in  1  single-cycle round-end pulse
//   round_win    in  1  result of the round, valid with round_done
//   game_end     in  1  level, high once the game is over
//   seg          out 8  {dp,g,f,e,d,c,b,a}, active-high, registered
//   digit_sel    out 4  one-hot digit enable, bit3 leftmost, registered
//   disp_state   out 2  FSM state
// ---------------------------------------------------------------------------
module score_display
  import game_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int FLASH_CYCLES = 2000,
  parameter int BLINK_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] level,
  input  logic [4:0] round_count,
  input  logic [3:0] answer_count,
  input  logic       round_done,
  input  logic       round_win,
  input  logic       game_end,
  output logic [7:0] seg,
  output logic [3:0] digit_sel,
  output logic [1:0] disp_state
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

  disp_state_t        state_r;
  disp_state_t        state_nxt_s;
  logic               flash_load_s;
  logic [FLASH_W-1:0] flash_cnt_r;
  logic               win_r;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [1:0]         scan_idx_r;
  logic [7:0]         seg_r;
  logic [3:0]         digit_sel_r;
  logic               level_ok_s;
  bcd_t               rnd_bcd_s;
  bcd_t               ans_bcd_s;
  glyph_t             glyph_s;
  logic [6:0]         pattern_s;
  logic               show_s;

  assign level_ok_s = level_is_valid(level);
  assign rnd_bcd_s  = bcd_split(round_count);
  assign ans_bcd_s  = bcd_split({1'b0, answer_count});

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; rule order gives the priority (no level > game end > round end)
  always_comb begin
    state_nxt_s  = state_r;
    flash_load_s = 1'b0;
    if (!level_ok_s) begin
      state_nxt_s = ST_IDLE;
    end else if (game_end) begin
      state_nxt_s = ST_RESULT;
    end else if (round_done && (state_r == ST_PLAY || state_r == ST_FLASH)) begin
      state_nxt_s  = ST_FLASH;
      flash_load_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = ST_PLAY;
        ST_PLAY:   state_nxt_s = ST_PLAY;
        ST_FLASH:  state_nxt_s = (flash_cnt_r == FLASH_W'(0)) ? ST_PLAY : ST_FLASH;
        ST_RESULT: state_nxt_s = ST_RESULT;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Flash window counter and latched round result; a new pulse restarts the window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_cnt_r <= FLASH_W'(0);
      win_r       <= 1'b0;
    end else if (flash_load_s) begin
      flash_cnt_r <= FLASH_W'(FLASH_CYCLES - 1);
      win_r       <= round_win;
    end else if (state_r == ST_FLASH && flash_cnt_r != FLASH_W'(0)) begin
      flash_cnt_r <= flash_cnt_r - FLASH_W'(1);
    end else begin
      flash_cnt_r <= flash_cnt_r;
    end
  end

  // Digit scan: each digit stays selected for SCAN_DIV cycles, digit0 first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_r <= SCAN_W'(0);
      scan_idx_r <= 2'd0;
    end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_r <= SCAN_W'(0);
      scan_idx_r <= scan_idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_on_r;

  // Result blink; held cleared outside RESULT so every entry starts in the on-phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_r <= BLINK_W'(0);
      blink_on_r  <= 1'b1;
    end else if (state_r != ST_RESULT) begin
      blink_cnt_r <= BLINK_W'(0);
      blink_on_r  <= 1'b1;
    end else if (blink_cnt_r == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_r <= BLINK_W'(0);
      blink_on_r  <= ~blink_on_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  assign show_s = (state_r != ST_RESULT) || blink_on_r;
`else
  assign show_s = 1'b1;
`endif

  // Glyph for the currently scanned digit in the current state (3 = leftmost)
  always_comb begin
    glyph_s = CH_BLANK;
    case (state_r)
      ST_IDLE: glyph_s = CH_DASH;
      ST_PLAY: begin
        case (scan_idx_r)
          2'd3: begin
            case (level)
              LVL_1:   glyph_s = CH_1;
              LVL_2:   glyph_s = CH_2;
              LVL_3:   glyph_s = CH_3;
              default: glyph_s = CH_BLANK;
            endcase
          end
          2'd2:    glyph_s = CH_BLANK;
          2'd1:    glyph_s = (rnd_bcd_s.tens == 2'd0) ? CH_BLANK
                                                      : digit_glyph({2'b00, rnd_bcd_s.tens});
          2'd0:    glyph_s = digit_glyph(rnd_bcd_s.ones);
          default: glyph_s = CH_BLANK;
        endcase
      end
      ST_FLASH: begin
        case (scan_idx_r)
          2'd3:    glyph_s = win_r ? CH_P : CH_F;
          2'd2:    glyph_s = CH_A;
          2'd1:    glyph_s = win_r ? CH_S : CH_I;
          2'd0:    glyph_s = win_r ? CH_S : CH_L;
          default: glyph_s = CH_BLANK;
        endcase
      end
      ST_RESULT: begin
        case (scan_idx_r)
          2'd3:    glyph_s = CH_S;
          2'd2:    glyph_s = CH_C;
          2'd1:    glyph_s = digit_glyph({2'b00, ans_bcd_s.tens});
          2'd0:    glyph_s = digit_glyph(ans_bcd_s.ones);
          default: glyph_s = CH_BLANK;
        endcase
      end
      default: glyph_s = CH_BLANK;
    endcase
  end

  seg_glyph_rom u_rom (
    .code    (glyph_s),
    .pattern (pattern_s)
  );

  // Output registers: segments and digit enable updated together, dp held low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_r       <= 8'h00;
      digit_sel_r <= 4'b0000;
    end else begin
      seg_r       <= show_s ? {1'b0, pattern_s} : 8'h00;
      digit_sel_r <= 4'b0001 << scan_idx_r;
    end
  end

  assign seg        = seg_r;
  assign digit_sel  = digit_sel_r;
  assign disp_state = state_r;

endmodule

// File: tb/tb_score_display.sv
// ---------------------------------------------------------------------------
// tb_score_display
// Directed test of score_display with SCAN_DIV=4, FLASH_CYCLES=6,
// BLINK_CYCLES=8. Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point. cyc counts rising edges since reset release,
// so the expected scanned digit for the edge just taken is ((cyc-1)/4)%4.
// ---------------------------------------------------------------------------
module tb_score_display;

  localparam logic [7:0] S_0  = 8'h3F;
  localparam logic [7:0] S_1  = 8'h06;
  localparam logic [7:0] S_2  = 8'h5B;
  localparam logic [7:0] S_3  = 8'h4F;
  localparam logic [7:0] S_5  = 8'h6D;
  localparam logic [7:0] S_7  = 8'h07;
  localparam logic [7:0] S_DS = 8'h40;
  localparam logic [7:0] S_BL = 8'h00;
  localparam logic [7:0] S_P  = 8'h73;
  localparam logic [7:0] S_A  = 8'h77;
  localparam logic [7:0] S_S  = 8'h6D;
  localparam logic [7:0] S_F  = 8'h71;
  localparam logic [7:0] S_I  = 8'h30;
  localparam logic [7:0] S_L  = 8'h38;
  localparam logic [7:0] S_C  = 8'h58;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level;
  logic [4:0] round_count;
  logic [3:0] answer_count;
  logic       round_done;
  logic       round_win;
  logic       game_end;
  logic [7:0] seg;
  logic [3:0] digit_sel;
  logic [1:0] disp_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rcyc   = 0;

  score_display #(
    .SCAN_DIV     (4),
    .FLASH_CYCLES (6),
    .BLINK_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .level        (level),
    .round_count  (round_count),
    .answer_count (answer_count),
    .round_done   (round_done),
    .round_win    (round_win),
    .game_end     (game_end),
    .seg          (seg),
    .digit_sel    (digit_sel),
    .disp_state   (disp_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) cyc++;
  endtask

  // pat = {digit3, digit2, digit1, digit0}; on=0 means blanked segments
  task automatic chk_disp(input string tag, input logic [31:0] pat, input logic on);
    int idx;
    idx = ((cyc - 1) / 4) % 4;
    chk({tag, "_sel"}, {28'd0, digit_sel}, {28'd0, 4'b0001 << idx});
    chk({tag, "_seg"}, {24'd0, seg}, on ? {24'd0, pat[idx*8 +: 8]} : 32'd0);
  endtask

  function automatic logic blink_on(input int j);
`ifdef SCORE_BLINK_EN
    return (((j - 1) / 8) % 2) == 0;
`else
    return (j >= 0);
`endif
  endfunction

  initial begin
    rst = 1'b0; level = 3'b010; round_count = 5'd13; answer_count = 4'd7;
    round_done = 1'b0; round_win = 1'b0; game_end = 1'b0;

    // 1. reset held while inputs toggle
    #1;
    chk("rst0_seg", {24'd0, seg}, 32'd0);
    chk("rst0_sel", {28'd0, digit_sel}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      level = 3'(1 << (i % 3)); round_done = i[0]; round_win = 1'b1; game_end = i[1];
      tick();
      chk("rst_seg", {24'd0, seg}, 32'd0);
      chk("rst_sel", {28'd0, digit_sel}, 32'd0);
      chk("rst_st", {30'd0, disp_state}, 32'd0);
    end

    // IDLE scan with no level
    level = 3'b000; round_done = 1'b0; round_win = 1'b0; game_end = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("idle_st", {30'd0, disp_state}, 32'd0);
      chk_disp("idle", {S_DS, S_DS, S_DS, S_DS}, 1'b1);
    end

    // 2. PLAY, level 2, round 13
    level = 3'b010; round_count = 5'd13;
    tick();
    chk("play_st", {30'd0, disp_state}, 32'd1);
    chk_disp("play_lat", {S_DS, S_DS, S_DS, S_DS}, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_disp("play13", {S_2, S_BL, S_1, S_3}, 1'b1);
    end
    round_count = 5'd5;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_disp("play05", {S_2, S_BL, S_BL, S_5}, 1'b1);
    end

    // 3a. win -> PASS for exactly 6 cycles
    round_done = 1'b1; round_win = 1'b1;
    tick();
    round_done = 1'b0;
    chk("fl_st1", {30'd0, disp_state}, 32'd2);
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk("fl_st", {30'd0, disp_state}, 32'd2);
      chk_disp("pass", {S_P, S_A, S_S, S_S}, 1'b1);
    end
    tick();
    chk("fl_end", {30'd0, disp_state}, 32'd1);
    chk_disp("pass_last", {S_P, S_A, S_S, S_S}, 1'b1);
    tick();
    chk_disp("play_back", {S_2, S_BL, S_BL, S_5}, 1'b1);

    // 3b. second pulse mid-window with loss restarts the window as FAIL
    round_done = 1'b1; round_win = 1'b1;
    tick();
    round_done = 1'b0;
    chk("fl2_st1", {30'd0, disp_state}, 32'd2);
    tick(); tick();
    chk_disp("pass2", {S_P, S_A, S_S, S_S}, 1'b1);
    round_done = 1'b1; round_win = 1'b0;
    tick();
    round_done = 1'b0;
    chk("fl2_st4", {30'd0, disp_state}, 32'd2);
    chk_disp("pass2_lat", {S_P, S_A, S_S, S_S}, 1'b1);
    for (int i = 5; i <= 9; i++) begin
      tick();
      chk("fl2_st", {30'd0, disp_state}, 32'd2);
      chk_disp("fail", {S_F, S_A, S_I, S_L}, 1'b1);
    end
    tick();
    chk("fl2_end", {30'd0, disp_state}, 32'd1);
    chk_disp("fail_last", {S_F, S_A, S_I, S_L}, 1'b1);

    // 4. game_end with round_done in the same cycle -> RESULT, no FLASH
    answer_count = 4'd7; round_done = 1'b1; round_win = 1'b1; game_end = 1'b1;
    tick();
    round_done = 1'b0;
    chk("res_st", {30'd0, disp_state}, 32'd3);
    rcyc = 0;
    for (int i = 0; i < 16; i++) begin
      tick(); rcyc++;
      chk("res_st_hold", {30'd0, disp_state}, 32'd3);
      chk_disp("sc07", {S_S, S_C, S_0, S_7}, blink_on(rcyc));
    end
    answer_count = 4'd12; round_done = 1'b1; round_win = 1'b0;
    tick(); rcyc++;
    round_done = 1'b0;
    chk("res_rd_ign", {30'd0, disp_state}, 32'd3);
    chk_disp("sc12_first", {S_S, S_C, S_1, S_2}, blink_on(rcyc));
    for (int i = 0; i < 15; i++) begin
      tick(); rcyc++;
      chk_disp("sc12", {S_S, S_C, S_1, S_2}, blink_on(rcyc));
    end

    // 5. level dropped in RESULT -> IDLE; non-one-hot level keeps IDLE
    level = 3'b000;
    tick();
    chk("idle2_st", {30'd0, disp_state}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_disp("idle2", {S_DS, S_DS, S_DS, S_DS}, 1'b1);
    end
    level = 3'b011;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle011_st", {30'd0, disp_state}, 32'd0);
      chk_disp("idle011", {S_DS, S_DS, S_DS, S_DS}, 1'b1);
    end

    // BCD boundaries in PLAY: 0, 31, 10; level re-select between valid levels
    game_end = 1'b0; level = 3'b001; round_count = 5'd0;
    tick();
    chk("play2_st", {30'd0, disp_state}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_disp("play_r00", {S_1, S_BL, S_BL, S_0}, 1'b1);
    end
    round_count = 5'd31;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_disp("play_r31", {S_1, S_BL, S_3, S_1}, 1'b1);
    end
    round_count = 5'd10; level = 3'b100;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("play3_st", {30'd0, disp_state}, 32'd1);
      chk_disp("play_r10", {S_3, S_BL, S_1, S_0}, 1'b1);
    end

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    chk("arst_seg", {24'd0, seg}, 32'd0);
    chk("arst_sel", {28'd0, digit_sel}, 32'd0);
    chk("arst_st", {30'd0, disp_state}, 32'd0);
    cyc = 0;
    rst = 1'b1;
    tick();
    chk("arst_play", {30'd0, disp_state}, 32'd1);
    chk_disp("arst_first", {S_DS, S_DS, S_DS, S_DS}, 1'b1);
    tick();
    chk_disp("arst_play", {S_3, S_BL, S_1, S_0}, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
